// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches against a credit limit,
// buffers responses with their PCs, and hands them to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemGnt,
  input  logic        i_IMemRValid,
  input  logic [31:0] i_IMemRData,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPc,
  output logic        o_InstrValid,
  input  logic        i_InstrReady,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_InstrPc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {FETCH, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] tag_pc_q     [FIFO_DEPTH];

  logic [CNT_W:0] credits_used;
  logic           req, gnt, rsp, push, pop, instr_valid;

  always_comb begin
    // Credits count both in-flight requests and buffered entries, so every
    // response is guaranteed a FIFO slot without a same-cycle pop bypass.
    credits_used = {1'b0, outstanding_q} + {1'b0, count_q};
    req          = i_Rst_n && (state_q == FETCH) && !i_Redirect
                   && (credits_used < {1'b0, DEPTH_C});
    gnt          = req && i_IMemGnt;
    rsp          = i_IMemRValid && (outstanding_q != '0);
    push         = rsp && (state_q == FETCH) && (drop_q == '0) && !i_Redirect;
    instr_valid  = (count_q != '0) && !i_Redirect;
    pop          = instr_valid && i_InstrReady;

    o_IMemReq     = req;
    o_IMemAddr    = fetch_pc_q;
    o_InstrValid  = instr_valid;
    o_Instruction = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP;
    o_InstrPc     = instr_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(rsp);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

    if (gnt) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = tag_wr_q + PTR_W'(1);
    end
    if (rsp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      tag_rd_d = tag_rd_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if ((state_q == FLUSH) && (drop_d == '0)) state_d = FETCH;

    // Redirect never coincides with a grant, so outstanding_d is exactly the
    // number of stale responses still to come back and be discarded.
    if (i_Redirect) begin
      fetch_pc_d = i_RedirectPc & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge i_Clk) begin
    if (gnt) tag_pc_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= tag_pc_q[tag_rd_q];
      fifo_instr_q[wr_ptr_q] <= i_IMemRData;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the SOIN-RV core. Owns the program counter, issues word requests to instruction memory, and buffers returned instructions in an in-order prefetch FIFO. Presents each instruction with its PC to the decode stage (decoder and immediate generator) over a valid/ready handshake. Supports redirects from branch/jump resolution, which flush all buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4: prefetch FIFO entries and maximum credits in use; power of two, >= 2.

- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- o_IMemReq  out  1  fetch request valid.
- o_IMemAddr  out  32  fetch address; always word-aligned.
- i_IMemGnt  in  1  request accepted when o_IMemReq & i_IMemGnt.
- i_IMemRValid  in  1  response valid; responses return in request order, >= 1 cycle after grant.
- i_IMemRData  in  32  response instruction word.
- i_Redirect  in  1  flush and restart fetch.
- i_RedirectPc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- o_InstrValid  out  1  o_Instruction/o_InstrPc valid.
- i_InstrReady  in  1  decode accepts; transfer when o_InstrValid & i_InstrReady.
- o_Instruction  out  32  instruction word; 32'h0000_0013 (NOP) when o_InstrValid = 0.
- o_InstrPc  out  32  PC of o_Instruction; 0 when o_InstrValid = 0.

## Operation
- State: FetchPc (32), Outstanding counter (0..FIFO_DEPTH), DropCount (0..FIFO_DEPTH), FIFO of {PC, instr} entries, FSM {FETCH, FLUSH}.
- Credit rule: o_IMemReq = (state == FETCH) & ~i_Redirect & (Outstanding + FIFO count < FIFO_DEPTH), using registered counts only (no same-cycle pop bypass).
- o_IMemAddr = FetchPc. On grant: FetchPc += 4 (wraps 32'hFFFF_FFFC -> 0), Outstanding += 1, and the granted PC is pushed to an in-order PC tag queue.
- Response in FETCH with DropCount = 0: push {tag PC, i_IMemRData} into FIFO, Outstanding -= 1. Credit rule guarantees space.
- Response when DropCount > 0: discard, DropCount -= 1, Outstanding -= 1.
- Response with Outstanding = 0: protocol violation; ignored, no counter change.
- Pop on o_InstrValid & i_InstrReady.
- Redirect (i_Redirect = 1):
  - FetchPc <= {i_RedirectPc[31:2], 2'b00}.
  - FIFO and PC tag queue flushed.
  - DropCount <= Outstanding after this cycle's response decrement.
  - o_InstrValid forced 0 combinationally, so no transfer occurs that cycle.
  - Next state: FLUSH if that DropCount > 0, else FETCH.
- FSM:
  - FETCH -> FLUSH on redirect with stale in-flight requests.
  - FLUSH -> FETCH when DropCount reaches 0.
  - FLUSH + redirect: update FetchPc, stay in FLUSH.
  - No requests are issued in FLUSH.

## Timing
- Reset (async assert): o_IMemReq = 0, o_IMemAddr = RESET_PC, o_InstrValid = 0, o_Instruction = 32'h0000_0013, o_InstrPc = 0; FIFO empty; counters 0; state FETCH.
- First o_IMemReq = 1 in the first cycle after i_Rst_n deasserts.
- Latency: response registered into FIFO at the edge ending its cycle; o_InstrValid high the next cycle. With 1-cycle memory, grant to o_InstrValid = 2 cycles.
- Sustained 1 instr/cycle with FIFO_DEPTH = 4, 1-cycle memory, and i_InstrReady held 1.
- Decode stall (i_InstrReady = 0): FIFO fills. o_IMemReq drops once Outstanding + count = FIFO_DEPTH. Outputs hold stable while valid & ~ready.
- Simultaneous push and pop in one cycle are both honoured; count unchanged.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release with Outstanding = 0 are ignored.

## Test plan
- Reset, i_IMemGnt = 1, memory latency 1, ready = 1 -> addresses 0,4,8,...; o_InstrPc/o_Instruction match memory, one per cycle from cycle 3.
- Hold i_InstrReady = 0 for 10 cycles -> exactly 4 grants, then o_IMemReq = 0; release -> 4 instructions in order, fetching resumes.
- Memory latency 3, 2 requests in flight, i_Redirect with i_RedirectPc = 32'h0000_0103 -> both stale responses dropped; next fetch at 32'h100; first o_InstrPc = 32'h100.
- Redirect in the same cycle as a response and a valid/ready pair -> response dropped, no transfer, FIFO empty next cycle.
- FetchPc at 32'hFFFF_FFFC -> next address 32'h0000_0000.
- Assert i_Rst_n = 0 mid-burst with 2 outstanding -> outputs at reset values immediately; late responses after release ignored; fetch restarts at RESET_PC.
